// File: rtl/zxuno_regport.sv
// zxuno_regport: Z80 I/O front end of the ZX-UNO extended register file.
// Decodes the register-address and register-data ports and drives the
// register-select bus for every downstream register block.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   a, iorq_n, m1_n     CPU address bus and cycle qualifiers
//   rd_n, wr_n, din     CPU strobes and write data
//   zxuno_addr          currently selected register number
//   zxuno_regrd         level, high while DATA_PORT is being read
//   zxuno_regwr         one-cycle pulse per DATA_PORT write
//   regaddr_changed     one-cycle pulse per ADDR_PORT write
//   dout, oe_n          readback of zxuno_addr for ADDR_PORT reads
module zxuno_regport #(
  parameter logic [15:0] ADDR_PORT = 16'hFC3B,
  parameter logic [15:0] DATA_PORT = 16'hFD3B
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] a,
  input  logic        iorq_n,
  input  logic        m1_n,
  input  logic        rd_n,
  input  logic        wr_n,
  input  logic [7:0]  din,
  output logic [7:0]  zxuno_addr,
  output logic        zxuno_regrd,
  output logic        zxuno_regwr,
  output logic        regaddr_changed,
  output logic [7:0]  dout,
  output logic        oe_n
);

  typedef enum logic [2:0] {
    IDLE,
    AWR,
    ARD,
    DRD,
    DWR,
    WEND
  } state_t;

  state_t state;
  state_t nxt;

  logic [15:0] s_a;
  logic        s_iorq_n;
  logic        s_m1_n;
  logic        s_rd_n;
  logic        s_wr_n;
  logic [7:0]  s_din;
  logic        s_vld;

  logic        prev_busy;

  logic        io;
  logic        rd;
  logic        wr;
  logic        busy;
  logic        hit_a;
  logic        hit_d;
  logic        start;

  // Input stage. Strobes come out of reset inactive; s_vld marks
  // that the stage holds a real bus sample rather than reset values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_a      <= 16'h0000;
      s_iorq_n <= 1'b1;
      s_m1_n   <= 1'b1;
      s_rd_n   <= 1'b1;
      s_wr_n   <= 1'b1;
      s_din    <= 8'h00;
      s_vld    <= 1'b0;
    end else begin
      s_a      <= a;
      s_iorq_n <= iorq_n;
      s_m1_n   <= m1_n;
      s_rd_n   <= rd_n;
      s_wr_n   <= wr_n;
      s_din    <= din;
      s_vld    <= 1'b1;
    end
  end

  always_comb begin
    io    = !s_iorq_n && s_m1_n;
    rd    = io && !s_rd_n && s_wr_n;
    wr    = io && !s_wr_n && s_rd_n;
    busy  = io && (!s_rd_n || !s_wr_n);
    hit_a = (s_a == ADDR_PORT);
    hit_d = (s_a == DATA_PORT);
    start = !prev_busy;
  end

  // An access only starts on a fresh strobe: the sample before must
  // have been inactive. This keeps a strobe held across reset, or
  // across an address change that ended a read, from re-triggering.
  always_comb begin
    nxt = state;
    unique case (state)
      IDLE: begin
        unique case (1'b1)
          start && wr && hit_a: nxt = AWR;
          start && rd && hit_a: nxt = ARD;
          start && rd && hit_d: nxt = DRD;
          start && wr && hit_d: nxt = DWR;
          default:              nxt = IDLE;
        endcase
      end
      AWR:  nxt = WEND;
      DWR:  nxt = WEND;
      ARD:  nxt = (rd && hit_a) ? ARD : IDLE;
      DRD:  nxt = (rd && hit_d) ? DRD : IDLE;
      WEND: nxt = (!io || s_wr_n) ? IDLE : WEND;
      default: nxt = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they change on
  // the same edge as the state itself.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      prev_busy       <= 1'b1;
      zxuno_addr      <= 8'h00;
      zxuno_regrd     <= 1'b0;
      zxuno_regwr     <= 1'b0;
      regaddr_changed <= 1'b0;
      dout            <= 8'h00;
      oe_n            <= 1'b1;
    end else begin
      state           <= nxt;
      prev_busy       <= s_vld ? busy : 1'b1;
      regaddr_changed <= (nxt == AWR);
      zxuno_regwr     <= (nxt == DWR);
      zxuno_regrd     <= (nxt == DRD);
      oe_n            <= (nxt != ARD);
      dout            <= (nxt == ARD) ? zxuno_addr : 8'h00;
      if (nxt == AWR) begin
        zxuno_addr <= s_din;
      end
    end
  end

endmodule
